pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit, the successor of the plain enable/reset PC register in the fetch stage. Holds the current instruction address and computes the next one from a per-cycle operation: sequential step, relative branch, absolute jump/load, call, and return. It adds a small circular return-address stack (RAS) so call/return sequences need no register-file traffic. It sits between the control unit (which supplies `op` and targets) and the instruction memory address port.

## Interface
Parameters:
- `WIDTH`, 16, address width in bits
- `RESET_PC`, 0, value loaded into `o_pc` on reset
- `STEP`, 1, sequential increment (1 = word addressing)
- `RAS_DEPTH`, 4, return-address stack entries (≥2)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `enable`  in  1  1 = execute `op` this edge; 0 = stall, all state held
- `op`  in  3  0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5 LOAD; 6–7 decode as SEQ
- `i_pc`  in  WIDTH  absolute target for JUMP/CALL/LOAD
- `i_offset`  in  WIDTH  two's-complement offset for BRANCH
- `o_pc`  out  WIDTH  current PC (registered)
- `o_link`  out  WIDTH  `o_pc + STEP`, combinational from `o_pc`
- `o_ras_depth`  out  clog2(RAS_DEPTH+1)  valid RAS entries (registered)
- `o_ras_full`  out  1  `o_ras_depth == RAS_DEPTH`
- `o_ras_empty`  out  1  `o_ras_depth == 0`
- `o_err`  out  1  one-cycle registered pulse on RAS overflow or underflow

## Operation
- Reset (`rst`=0): `o_pc`=RESET_PC, depth 0, top pointer 0, `o_err`=0; RAS contents are don't-care.
- On each rising edge with `enable`=1:
  - SEQ: `o_pc` ← `o_pc + STEP`.
  - BRANCH: `o_pc` ← `o_pc + i_offset`.
  - JUMP, LOAD: `o_pc` ← `i_pc`. LOAD is kept as an alias of JUMP for compatibility with the previous PC block.
  - CALL: push `o_pc + STEP`, then `o_pc` ← `i_pc`.
  - RET, non-empty: pop the top entry into `o_pc`; depth −1.
  - RET, empty: `o_pc` ← `o_pc + STEP`; depth stays 0; `o_err`=1.
- All arithmetic is modulo 2^WIDTH. Carries are discarded. No saturation.
- The RAS is a circular buffer with a top pointer.
  - CALL when full overwrites the oldest entry. Depth stays RAS_DEPTH and `o_err`=1. The newest RAS_DEPTH return addresses are always retained.
- `o_err` is 0 on every edge with no overflow or underflow, including stalled edges.
- `enable`=0: `o_pc`, RAS, depth and pointer are unchanged; `op`, `i_pc` and `i_offset` are ignored.

## Timing
- Single clock domain. All state updates on the rising edge of `clk` when `enable`=1.
- Latency: one cycle from `op` sample to new `o_pc`. `o_link`, `o_ras_full` and `o_ras_empty` follow their registers combinationally.
- Reset asserts asynchronously: outputs take reset values immediately, without waiting for an edge. Deassertion is released synchronously by the system reset generator.
- Reset mid-sequence (any depth, any op) discards the RAS. The first edge after release executes `op` from RESET_PC.
- Only one op per cycle, so push and pop are never simultaneous.
- All inputs must be stable at the sampling edge.

## Test plan
Defaults: WIDTH=16, STEP=1, RAS_DEPTH=4, RESET_PC=0000.
- Reset/sequence: hold `rst`=0 with `enable`=1, `i_pc`=ffff, op=LOAD -> `o_pc`=0000 and `o_ras_empty`=1. Release `rst`, then 3 SEQ edges -> 0001, 0002, 0003.
- Wrap/branch: LOAD ffff, then SEQ -> 0000. LOAD 0010, then BRANCH `i_offset`=fffe -> 000e. BRANCH 0004 -> 0012.
- Stall: `enable`=0 with op=JUMP, `i_pc`=ff33 for 2 edges -> `o_pc` and depth unchanged, `o_err`=0. Set `enable`=1 -> `o_pc`=ff33 one edge later.
- Nested call/return, starting at 0020:
  - CALL 0100 -> `o_pc`=0100, depth 1.
  - CALL 0200 -> 0200, depth 2.
  - RET -> 0101, depth 1.
  - RET -> 0021, `o_ras_empty`=1, `o_err` never asserted.
- Overflow/underflow, starting at 0000:
  - CALLs to 0010, 0020, 0030, 0040, 0050 -> `o_err`=1 only on the 5th edge; depth 4, `o_ras_full`=1.
  - 4 RETs -> 0041, 0031, 0021, 0011.
  - 5th RET -> `o_pc`=0012, `o_err`=1 for exactly one cycle.
- Async reset mid-operation: with depth 3 and `o_pc`=0200, pull `rst`=0 between edges -> `o_pc`=0000 and depth 0 before the next edge. After release, RET -> `o_pc`=0001, `o_err`=1.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter with sequential/branch/jump/call/return ops
// and a circular return-address stack.
module pc_unit #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               STEP      = 1,
  parameter int               RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [2:0]                     op,
  input  logic [WIDTH-1:0]               i_pc,
  input  logic [WIDTH-1:0]               i_offset,
  output logic [WIDTH-1:0]               o_pc,
  output logic [WIDTH-1:0]               o_link,
  output logic [$clog2(RAS_DEPTH+1)-1:0] o_ras_depth,
  output logic                           o_ras_full,
  output logic                           o_ras_empty,
  output logic                           o_err
);

  localparam int DW = $clog2(RAS_DEPTH + 1);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_SEQ    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_LOAD   = 3'd5
  } op_e;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] link;
  logic [DW-1:0]    depth_q;
  logic [DW-1:0]    depth_d;
  logic [PW-1:0]    top_q;
  logic [PW-1:0]    top_d;
  logic [PW-1:0]    top_inc;
  logic [PW-1:0]    top_dec;
  logic             err_q;
  logic             err_d;
  logic             push;
  logic             full;
  logic             empty;
  logic             is_br;
  logic             is_jmp;
  logic             is_call;
  logic             is_ret;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  assign link  = pc_q + WIDTH'(STEP);
  assign full  = (depth_q == DW'(RAS_DEPTH));
  assign empty = (depth_q == '0);

  assign is_br   = (op == OP_BRANCH);
  assign is_jmp  = (op == OP_JUMP) || (op == OP_LOAD);
  assign is_call = (op == OP_CALL);
  assign is_ret  = (op == OP_RET);

  // top_q names the next free slot; wrap explicitly for any depth
  assign top_inc = (top_q == PW'(RAS_DEPTH - 1)) ? '0
                 : top_q + PW'(1);
  assign top_dec = (top_q == '0) ? PW'(RAS_DEPTH - 1)
                 : top_q - PW'(1);

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    top_d   = top_q;
    err_d   = 1'b0;
    push    = 1'b0;
    if (enable) begin
      unique case (1'b1)
        is_br: begin
          pc_d = pc_q + i_offset;
        end
        is_jmp: begin
          pc_d = i_pc;
        end
        is_call: begin
          push  = 1'b1;
          pc_d  = i_pc;
          top_d = top_inc;
          if (full) err_d = 1'b1;
          else      depth_d = depth_q + DW'(1);
        end
        is_ret: begin
          if (empty) begin
            pc_d  = link;
            err_d = 1'b1;
          end else begin
            pc_d    = ras_q[top_dec];
            top_d   = top_dec;
            depth_d = depth_q - DW'(1);
          end
        end
        default: begin
          pc_d = link;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      depth_q <= '0;
      top_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      top_q   <= top_d;
      err_q   <= err_d;
    end
  end

  // Stack contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (push) ras_q[top_q] <= link;
  end

  assign o_pc        = pc_q;
  assign o_link      = link;
  assign o_ras_depth = depth_q;
  assign o_ras_full  = full;
  assign o_ras_empty = empty;
  assign o_err       = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Randomised and directed bench for pc_unit against a
// queue-based reference model.
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [2:0]  op;
  logic [15:0] i_pc;
  logic [15:0] i_offset;
  logic [15:0] o_pc;
  logic [15:0] o_link;
  logic [2:0]  o_ras_depth;
  logic        o_ras_full;
  logic        o_ras_empty;
  logic        o_err;

  int n_vec;
  int n_bad;

  logic [15:0] m_pc;
  logic        m_err;
  logic [15:0] m_ras [$];

  pc_unit dut (
    .clk         (clk),
    .rst         (rst_n),
    .enable      (enable),
    .op          (op),
    .i_pc        (i_pc),
    .i_offset    (i_offset),
    .o_pc        (o_pc),
    .o_link      (o_link),
    .o_ras_depth (o_ras_depth),
    .o_ras_full  (o_ras_full),
    .o_ras_empty (o_ras_empty),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_pc  = 16'h0000;
    m_err = 1'b0;
    m_ras.delete();
  endfunction

  function automatic void m_apply(input logic en,
                                  input logic [2:0] o,
                                  input logic [15:0] a,
                                  input logic [15:0] off);
    m_err = 1'b0;
    if (!en) return;
    case (o)
      3'd1: m_pc = m_pc + off;
      3'd2, 3'd5: m_pc = a;
      3'd3: begin
        m_ras.push_back(m_pc + 16'd1);
        if (m_ras.size() > 4) begin
          void'(m_ras.pop_front());
          m_err = 1'b1;
        end
        m_pc = a;
      end
      3'd4: begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin
          m_pc  = m_pc + 16'd1;
          m_err = 1'b1;
        end
      end
      default: m_pc = m_pc + 16'd1;
    endcase
  endfunction

  task automatic check_all();
    logic [15:0] lk;
    lk = m_pc + 16'd1;
    chk("pc", {16'h0, o_pc}, {16'h0, m_pc});
    chk("link", {16'h0, o_link}, {16'h0, lk});
    chk("depth", {29'h0, o_ras_depth}, m_ras.size());
    chk("full", {31'h0, o_ras_full}, {31'h0, m_ras.size() == 4});
    chk("empty", {31'h0, o_ras_empty}, {31'h0, m_ras.size() == 0});
    chk("err", {31'h0, o_err}, {31'h0, m_err});
  endtask

  task automatic step(input logic en,
                      input logic [2:0] o,
                      input logic [15:0] a,
                      input logic [15:0] off);
    enable   = en;
    op       = o;
    i_pc     = a;
    i_offset = off;
    @(posedge clk);
    m_apply(en, o, a, off);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_pc", {16'h0, o_pc}, 32'h0);
    chk("arst_depth", {29'h0, o_ras_depth}, 32'h0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    enable   = 1'b1;
    op       = 3'd5;
    i_pc     = 16'hffff;
    i_offset = 16'h0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", {16'h0, o_pc}, 32'h0);
    chk("rst_empty", {31'h0, o_ras_empty}, 32'h1);
    check_all();
    rst_n = 1'b1;

    step(1, 3'd0, 16'h0, 16'h0);
    chk("seq1", {16'h0, o_pc}, 32'h0001);
    step(1, 3'd0, 16'h0, 16'h0);
    step(1, 3'd0, 16'h0, 16'h0);
    chk("seq3", {16'h0, o_pc}, 32'h0003);

    step(1, 3'd5, 16'hffff, 16'h0);
    step(1, 3'd0, 16'h0, 16'h0);
    chk("wrap", {16'h0, o_pc}, 32'h0000);
    step(1, 3'd5, 16'h0010, 16'h0);
    step(1, 3'd1, 16'h0, 16'hfffe);
    chk("br_neg", {16'h0, o_pc}, 32'h000e);
    step(1, 3'd1, 16'h0, 16'h0004);
    chk("br_pos", {16'h0, o_pc}, 32'h0012);

    step(0, 3'd2, 16'hff33, 16'h0);
    step(0, 3'd2, 16'hff33, 16'h0);
    chk("stall", {16'h0, o_pc}, 32'h0012);
    step(1, 3'd2, 16'hff33, 16'h0);
    chk("unstall", {16'h0, o_pc}, 32'hff33);

    step(1, 3'd2, 16'h0020, 16'h0);
    step(1, 3'd3, 16'h0100, 16'h0);
    step(1, 3'd3, 16'h0200, 16'h0);
    step(1, 3'd4, 16'h0, 16'h0);
    chk("ret1", {16'h0, o_pc}, 32'h0101);
    step(1, 3'd4, 16'h0, 16'h0);
    chk("ret2", {16'h0, o_pc}, 32'h0021);

    step(1, 3'd2, 16'h0000, 16'h0);
    for (int i = 1; i <= 5; i++)
      step(1, 3'd3, 16'(i * 16), 16'h0);
    chk("ovf_err", {31'h0, o_err}, 32'h1);
    chk("ovf_full", {31'h0, o_ras_full}, 32'h1);
    for (int i = 0; i < 4; i++)
      step(1, 3'd4, 16'h0, 16'h0);
    chk("ret_last", {16'h0, o_pc}, 32'h0011);
    step(1, 3'd4, 16'h0, 16'h0);
    chk("unf_pc", {16'h0, o_pc}, 32'h0012);
    chk("unf_err", {31'h0, o_err}, 32'h1);
    step(1, 3'd0, 16'h0, 16'h0);

    step(1, 3'd2, 16'h0000, 16'h0);
    step(1, 3'd3, 16'h0100, 16'h0);
    step(1, 3'd3, 16'h0150, 16'h0);
    step(1, 3'd3, 16'h0200, 16'h0);
    async_reset();
    step(1, 3'd4, 16'h0, 16'h0);
    chk("post_rst_ret", {16'h0, o_pc}, 32'h0001);
    chk("post_rst_err", {31'h0, o_err}, 32'h1);

    for (int i = 0; i < 600; i++) begin
      logic        en;
      logic [2:0]  o;
      logic [15:0] a;
      logic [15:0] off;
      en  = ($urandom_range(0, 9) != 0);
      o   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) o = 3'd3;
      else if ($urandom_range(0, 2) == 0) o = 3'd4;
      a   = 16'($urandom);
      off = 16'($urandom);
      if ($urandom_range(0, 99) == 0) async_reset();
      step(en, o, a, off);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
